// File: rtl/fifo_wr_arb_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb_if
// Purpose : bundles the two requester handshakes and the FIFO write port of
//           the fifo_wr_arb arbiter into one interface.
// Signals : i_req0_* / i_req1_*  valid, data, last  (requester -> arbiter)
//           o_req0_ready / o_req1_ready            (arbiter -> requester)
//           o_fifo_wr_en, o_fifo_data              (arbiter -> FIFO)
//           i_fifo_full                            (FIFO -> arbiter)
//           o_grant, o_trunc                       (arbiter status)
// Modports: slave  - arbiter view (i_* in, o_* out)
//           master - environment view (drives i_*, observes o_*)
// ---------------------------------------------------------------------------
interface fifo_wr_arb_if #(
    parameter int DataWidth = 8
);
    logic                 i_req0_valid;
    logic                 i_req1_valid;
    logic [DataWidth-1:0] i_req0_data;
    logic [DataWidth-1:0] i_req1_data;
    logic                 i_req0_last;
    logic                 i_req1_last;
    logic                 o_req0_ready;
    logic                 o_req1_ready;
    logic                 o_fifo_wr_en;
    logic [DataWidth-1:0] o_fifo_data;
    logic                 i_fifo_full;
    logic [1:0]           o_grant;
    logic                 o_trunc;

    modport slave (
        input  i_req0_valid, i_req1_valid,
        input  i_req0_data,  i_req1_data,
        input  i_req0_last,  i_req1_last,
        input  i_fifo_full,
        output o_req0_ready, o_req1_ready,
        output o_fifo_wr_en, o_fifo_data,
        output o_grant,      o_trunc
    );

    modport master (
        output i_req0_valid, i_req1_valid,
        output i_req0_data,  i_req1_data,
        output i_req0_last,  i_req1_last,
        output i_fifo_full,
        input  o_req0_ready, o_req1_ready,
        input  o_fifo_wr_en, o_fifo_data,
        input  o_grant,      o_trunc
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
// Purpose : two-requester packet arbiter in front of a single FIFO write port.
//           A grant is held for a whole packet (until a last beat), or is
//           forcibly released after MaxBeats beats (o_trunc pulse). Ties are
//           broken round-robin; requester 0 wins the first contention.
//
//   state | meaning
//   IDLE  | no owner, both readys low; picks next owner from valids
//   GNT0  | requester 0 owns the FIFO (o_grant = 01)
//   GNT1  | requester 1 owns the FIFO (o_grant = 10)
//
// Ports   : i_clk, i_rst_n (async, active-low)
//           bus  : fifo_wr_arb_if.slave (requester handshakes, FIFO port,
//                  o_grant, o_trunc)
//           o_pkt_cnt0/1 : completed packets per requester, only when the
//                  macro FIFO_WR_ARB_CNT_EN is defined
// Macro   : FIFO_WR_ARB_CNT_EN enables the per-requester packet counters.
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int DataWidth = 8,
    parameter int MaxBeats  = 16,
    parameter int CntWidth  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    fifo_wr_arb_if.slave        bus
`ifdef FIFO_WR_ARB_CNT_EN
    ,
    output logic [CntWidth-1:0] o_pkt_cnt0,
    output logic [CntWidth-1:0] o_pkt_cnt1
`endif
);

    // Elaboration-time sanity check on the parameters.
    if (MaxBeats < 1 || CntWidth < 1 || DataWidth < 1) begin : g_param_check
        $error("fifo_wr_arb: DataWidth, MaxBeats and CntWidth must be >= 1");
    end

    localparam int                   BeatWidth = $clog2(MaxBeats + 1);
    localparam logic [BeatWidth-1:0] BeatLast  = BeatWidth'(MaxBeats - 1);

    // State encoding equals the grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t               r_state;
    logic [1:0]           r_grant;
    logic [BeatWidth-1:0] r_beat_cnt;
    logic                 r_rr_last;    // 1: requester 1 was served most recently

    logic                 w_sel0;
    logic                 w_sel1;
    logic                 w_valid;
    logic                 w_last;
    logic [DataWidth-1:0] w_data;
    logic                 w_xfer;
    logic                 w_at_max;
    logic                 w_end_pkt;
    logic                 w_trunc;
    logic                 w_release;

    assign w_sel0 = (r_state == GNT0);
    assign w_sel1 = (r_state == GNT1);

    always_comb begin
        w_valid = 1'b0;
        w_last  = 1'b0;
        w_data  = '0;
        if (w_sel0) begin
            w_valid = bus.i_req0_valid;
            w_last  = bus.i_req0_last;
            w_data  = bus.i_req0_data;
        end else if (w_sel1) begin
            w_valid = bus.i_req1_valid;
            w_last  = bus.i_req1_last;
            w_data  = bus.i_req1_data;
        end
    end

    // A full FIFO stalls the owner without any timeout.
    assign w_xfer    = w_valid & ~bus.i_fifo_full;
    assign w_at_max  = (r_beat_cnt == BeatLast);
    assign w_end_pkt = w_xfer & w_last;
    assign w_trunc   = w_xfer & ~w_last & w_at_max;
    assign w_release = w_end_pkt | w_trunc;

    // Handshake and write port are combinational from the registered grant
    // so a beat is written in the same cycle it is accepted.
    assign bus.o_req0_ready = w_sel0 & ~bus.i_fifo_full;
    assign bus.o_req1_ready = w_sel1 & ~bus.i_fifo_full;
    assign bus.o_fifo_wr_en = w_xfer;
    assign bus.o_fifo_data  = w_data;
    assign bus.o_trunc      = w_trunc;
    assign bus.o_grant      = r_grant;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_grant    <= 2'b00;
            r_beat_cnt <= '0;
            r_rr_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_req0_valid && (!bus.i_req1_valid || r_rr_last)) begin
                        r_state    <= GNT0;
                        r_grant    <= 2'b01;
                        r_beat_cnt <= '0;
                    end else if (bus.i_req1_valid) begin
                        r_state    <= GNT1;
                        r_grant    <= 2'b10;
                        r_beat_cnt <= '0;
                    end
                end
                GNT0, GNT1: begin
                    // Returning to IDLE provides the one-cycle bubble before
                    // the next grant; a truncated remainder re-arbitrates as
                    // a new packet.
                    if (w_release) begin
                        r_state   <= IDLE;
                        r_grant   <= 2'b00;
                        r_rr_last <= w_sel1;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_CNT_EN
    logic [CntWidth-1:0] r_pkt_cnt0;
    logic [CntWidth-1:0] r_pkt_cnt1;

    // Truncations count as a completed packet; counters wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else begin
            if (w_release && w_sel0) begin
                r_pkt_cnt0 <= r_pkt_cnt0 + 1'b1;
            end
            if (w_release && w_sel1) begin
                r_pkt_cnt1 <= r_pkt_cnt1 + 1'b1;
            end
        end
    end

    assign o_pkt_cnt0 = r_pkt_cnt0;
    assign o_pkt_cnt1 = r_pkt_cnt1;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arb
// Directed bench for fifo_wr_arb built with MaxBeats = 4. Inputs change one
// time unit after the rising edge; outputs are sampled one unit later. A
// negedge monitor logs every FIFO write so packet ordering can be compared
// against hand-written expected sequences.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb;

    localparam int DataWidth = 8;
    localparam int MaxBeats  = 4;
    localparam int CntWidth  = 16;

    logic clk_sys;
    logic rst_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [DataWidth-1:0] wr_log[$];
    logic [DataWidth-1:0] exp_q[$];

    fifo_wr_arb_if #(.DataWidth(DataWidth)) bus ();

`ifdef FIFO_WR_ARB_CNT_EN
    logic [CntWidth-1:0] pkt_cnt0;
    logic [CntWidth-1:0] pkt_cnt1;
`endif

    fifo_wr_arb #(
        .DataWidth (DataWidth),
        .MaxBeats  (MaxBeats),
        .CntWidth  (CntWidth)
    ) u_dut (
        .i_clk      (clk_sys),
        .i_rst_n    (rst_b),
        .bus        (bus)
`ifdef FIFO_WR_ARB_CNT_EN
        ,
        .o_pkt_cnt0 (pkt_cnt0),
        .o_pkt_cnt1 (pkt_cnt1)
`endif
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (bus.o_fifo_wr_en) wr_log.push_back(bus.o_fifo_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] gnt, input logic rdy0,
                            input logic rdy1, input logic we, input logic [7:0] data,
                            input logic trunc);
        chk({tag, "_grant"}, 32'(bus.o_grant), 32'(gnt));
        chk({tag, "_rdy0"},  32'(bus.o_req0_ready), 32'(rdy0));
        chk({tag, "_rdy1"},  32'(bus.o_req1_ready), 32'(rdy1));
        chk({tag, "_wren"},  32'(bus.o_fifo_wr_en), 32'(we));
        chk({tag, "_data"},  32'(bus.o_fifo_data), 32'(data));
        chk({tag, "_trunc"}, 32'(bus.o_trunc), 32'(trunc));
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_nwr"}, 32'(wr_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_log.size()) chk({tag, "_wr"}, 32'(wr_log[i]), 32'(exp_q[i]));
        end
        wr_log.delete();
        exp_q.delete();
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        bus.i_req0_data  = '0;
        bus.i_req1_data  = '0;
        bus.i_req0_last  = 1'b0;
        bus.i_req1_last  = 1'b0;
        bus.i_fifo_full  = 1'b0;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        idle_inputs();
        repeat (2) cyc();
        rst_b = 1'b1;
        wr_log.delete();
    endtask

    initial begin
        rst_b = 1'b0;
        idle_inputs();
        #3;
        chk_outs("rst", 2'b00, 0, 0, 0, 8'h00, 0);
`ifdef FIFO_WR_ARB_CNT_EN
        chk("rst_cnt0", 32'(pkt_cnt0), 0);
        chk("rst_cnt1", 32'(pkt_cnt1), 0);
`endif
        cyc();
        cyc();
        rst_b = 1'b1;
        wr_log.delete();

        // Single requester, 3-beat packet.
        bus.i_req0_valid = 1; bus.i_req0_data = 8'hA1;
        #1 chk_outs("a_idle", 2'b00, 0, 0, 0, 8'h00, 0);
        cyc();
        #1 chk_outs("a_b1", 2'b01, 1, 0, 1, 8'hA1, 0);
        cyc();
        bus.i_req0_data = 8'hA2;
        #1 chk_outs("a_b2", 2'b01, 1, 0, 1, 8'hA2, 0);
        cyc();
        bus.i_req0_data = 8'hA3; bus.i_req0_last = 1;
        #1 chk_outs("a_b3", 2'b01, 1, 0, 1, 8'hA3, 0);
        cyc();
        idle_inputs();
        #1 chk_outs("a_end", 2'b00, 0, 0, 0, 8'h00, 0);
`ifdef FIFO_WR_ARB_CNT_EN
        chk("a_cnt0", 32'(pkt_cnt0), 1);
`endif
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        chk_log("a_log");

        // Contention after reset: requester 0 first, bubble, then requester 1.
        do_reset();
        bus.i_req0_valid = 1; bus.i_req0_data = 8'h10;
        bus.i_req1_valid = 1; bus.i_req1_data = 8'h20;
        #1 chk_outs("b_idle", 2'b00, 0, 0, 0, 8'h00, 0);
        cyc();
        #1 chk_outs("b_r0b0", 2'b01, 1, 0, 1, 8'h10, 0);
        cyc();
        bus.i_req0_data = 8'h11; bus.i_req0_last = 1;
        #1 chk_outs("b_r0b1", 2'b01, 1, 0, 1, 8'h11, 0);
        cyc();
        bus.i_req0_valid = 0; bus.i_req0_last = 0;
        #1 chk_outs("b_bubble", 2'b00, 0, 0, 0, 8'h00, 0);
        cyc();
        #1 chk_outs("b_r1b0", 2'b10, 0, 1, 1, 8'h20, 0);
        cyc();
        bus.i_req1_data = 8'h21; bus.i_req1_last = 1;
        #1 chk_outs("b_r1b1", 2'b10, 0, 1, 1, 8'h21, 0);
        cyc();
        idle_inputs();
        #1 chk_outs("b_end", 2'b00, 0, 0, 0, 8'h00, 0);
        exp_q = '{8'h10, 8'h11, 8'h20, 8'h21};
        chk_log("b_log");

        // FIFO full for 4 cycles mid-packet.
        bus.i_req0_valid = 1; bus.i_req0_data = 8'hB1;
        cyc();
        #1 chk_outs("c_b1", 2'b01, 1, 0, 1, 8'hB1, 0);
        cyc();
        bus.i_req0_data = 8'hB2; bus.i_fifo_full = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk_outs("c_full", 2'b01, 0, 0, 0, 8'hB2, 0);
            cyc();
        end
        bus.i_fifo_full = 0;
        #1 chk_outs("c_b2", 2'b01, 1, 0, 1, 8'hB2, 0);
        cyc();
        bus.i_req0_data = 8'hB3; bus.i_req0_last = 1;
        #1 chk_outs("c_b3", 2'b01, 1, 0, 1, 8'hB3, 0);
        cyc();
        idle_inputs();
        #1 chk_outs("c_end", 2'b00, 0, 0, 0, 8'h00, 0);
        exp_q = '{8'hB1, 8'hB2, 8'hB3};
        chk_log("c_log");

        // Truncation: requester 1 streams 6 beats with MaxBeats = 4.
        do_reset();
        bus.i_req1_valid = 1; bus.i_req1_data = 8'hC1;
        #1 chk_outs("d_idle", 2'b00, 0, 0, 0, 8'h00, 0);
        cyc();
        for (int k = 1; k <= 4; k++) begin
            bus.i_req1_data = 8'(8'hC0 + k);
            #1 chk_outs("d_beat", 2'b10, 0, 1, 1, 8'(8'hC0 + k), (k == 4));
            cyc();
        end
        bus.i_req1_data = 8'hC5;
        #1 chk_outs("d_regrant", 2'b00, 0, 0, 0, 8'h00, 0);
        cyc();
        for (int k = 5; k <= 6; k++) begin
            bus.i_req1_data = 8'(8'hC0 + k);
            bus.i_req1_last = (k == 6);
            #1 chk_outs("d_tail", 2'b10, 0, 1, 1, 8'(8'hC0 + k), 0);
            cyc();
        end
        idle_inputs();
        #1 chk_outs("d_end", 2'b00, 0, 0, 0, 8'h00, 0);
`ifdef FIFO_WR_ARB_CNT_EN
        chk("d_cnt1", 32'(pkt_cnt1), 2);
        chk("d_cnt0", 32'(pkt_cnt0), 0);
`endif
        exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        chk_log("d_log");

        // Reset asserted during beat 2 of a 4-beat packet.
        bus.i_req0_valid = 1; bus.i_req0_data = 8'hE1;
        cyc();
        #1 chk_outs("e_b1", 2'b01, 1, 0, 1, 8'hE1, 0);
        cyc();
        bus.i_req0_data = 8'hE2;
        #1 chk_outs("e_b2", 2'b01, 1, 0, 1, 8'hE2, 0);
        rst_b = 1'b0;
        #1 chk_outs("e_rst", 2'b00, 0, 0, 0, 8'h00, 0);
        cyc();
        idle_inputs();
        cyc();
        rst_b = 1'b1;
        exp_q = '{8'hE1};
        chk_log("e_log");
        bus.i_req1_valid = 1; bus.i_req1_data = 8'hF1; bus.i_req1_last = 1;
        #1 chk_outs("e_idle", 2'b00, 0, 0, 0, 8'h00, 0);
        cyc();
        #1 chk_outs("e_r1", 2'b10, 0, 1, 1, 8'hF1, 0);
        cyc();
        idle_inputs();
        #1 chk_outs("e_end", 2'b00, 0, 0, 0, 8'h00, 0);
        exp_q = '{8'hF1};
        chk_log("e_log2");

        // Requester 0 stalls valid mid-packet while requester 1 waits.
        bus.i_req0_valid = 1; bus.i_req0_data = 8'h61;
        bus.i_req1_valid = 1; bus.i_req1_data = 8'h71; bus.i_req1_last = 1;
        cyc();
        #1 chk_outs("f_b1", 2'b01, 1, 0, 1, 8'h61, 0);
        cyc();
        bus.i_req0_valid = 0; bus.i_req0_data = 8'h62;
        for (int i = 0; i < 3; i++) begin
            #1 chk_outs("f_gap", 2'b01, 1, 0, 0, 8'h62, 0);
            cyc();
        end
        bus.i_req0_valid = 1;
        #1 chk_outs("f_b2", 2'b01, 1, 0, 1, 8'h62, 0);
        cyc();
        bus.i_req0_data = 8'h63; bus.i_req0_last = 1;
        #1 chk_outs("f_b3", 2'b01, 1, 0, 1, 8'h63, 0);
        cyc();
        bus.i_req0_valid = 0; bus.i_req0_last = 0;
        #1 chk_outs("f_bubble", 2'b00, 0, 0, 0, 8'h00, 0);
        cyc();
        #1 chk_outs("f_r1", 2'b10, 0, 1, 1, 8'h71, 0);
        cyc();
        idle_inputs();
        #1 chk_outs("f_end", 2'b00, 0, 0, 0, 8'h00, 0);
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h71};
        chk_log("f_log");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
- Parameters
  - REQ-001: DataWidth, default 8; width of every data bus in bits.
  - REQ-002: MaxBeats, default 16; maximum number of beats in one packet before the grant is forcibly released.
  - REQ-003: CntWidth, default 16; width of each packet counter.
- Ports
  - REQ-004: i_clk  in  1  single clock; all logic samples on the rising edge.
  - REQ-005: i_rst_n  in  1  reset, asynchronous, active-low.
  - REQ-006: i_req0_valid, i_req1_valid  in  1 each  requester offers a beat.
  - REQ-007: i_req0_data, i_req1_data  in  DataWidth each  beat payload.
  - REQ-008: i_req0_last, i_req1_last  in  1 each  beat is the final beat of its packet.
  - REQ-009: o_req0_ready, o_req1_ready  out  1 each  beat is accepted in this cycle.
  - REQ-010: o_fifo_wr_en  out  1  FIFO write strobe.
  - REQ-011: o_fifo_data  out  DataWidth  FIFO write data.
  - REQ-012: i_fifo_full  in  1  FIFO full flag.
  - REQ-013: o_grant  out  2  one-hot owner; bit n set means requester n owns the FIFO; 00 when idle.
  - REQ-014: o_trunc  out  1  one-cycle pulse when a packet is force-released.
  - REQ-015: o_pkt_cnt0, o_pkt_cnt1  out  CntWidth each  packets completed per requester; present only under FIFO_WR_ARB_CNT_EN.

Function
- REQ-016: The FSM SHALL have exactly three states: IDLE, GNT0, GNT1; o_grant is 00, 01 or 10 respectively.
- REQ-017: In IDLE, the FSM SHALL move next cycle to GNT0 or GNT1 when any valid is high; if no valid is high it stays in IDLE.
  - With one valid high, that requester is granted.
  - With both valids high, the requester not served most recently (rr_last) is granted.
- REQ-018: In GNTn, ready_n SHALL equal !i_fifo_full, combinationally.
  - The other requester's ready SHALL be 0.
  - In IDLE, both readys SHALL be 0.
- REQ-019: A transfer occurs when the granted valid and ready are both high.
  - o_fifo_wr_en SHALL equal transfer, in the same cycle (zero latency).
  - o_fifo_data SHALL equal the granted requester's data.
  - o_fifo_data is 0 when no grant is held.
- REQ-020: A beat counter SHALL reset to 0 on entry to GNTn and increment on each transfer.
- REQ-021: On a transfer with last=1, the FSM SHALL return to IDLE, set rr_last=n, and leave one idle bubble cycle before the next grant.
- REQ-022: On a transfer where the beat counter equals MaxBeats-1 and last=0, the FSM SHALL return to IDLE and set rr_last=n.
  - o_trunc pulses for exactly that cycle.
  - The remainder of the packet is treated as a new packet.
- REQ-023: If i_fifo_full is high in GNTn, the grant SHALL be held with no transfer and no timeout.
- REQ-024: A requester dropping valid mid-packet SHALL keep the grant; the FSM waits indefinitely.
- REQ-025: rr_last SHALL reset to 1 so that requester 0 wins the first contention.

Reset
- REQ-026: Assertion of i_rst_n low SHALL immediately force all outputs to their reset values:
  - FSM=IDLE, o_grant=00, readys=0, o_fifo_wr_en=0, o_fifo_data=0, o_trunc=0;
  - beat counter=0, rr_last=1, packet counters=0.
- REQ-027: Reset mid-packet SHALL abandon the packet with no further writes.
  - The first grant after deassertion follows REQ-017.

Configuration
- REQ-028: When macro FIFO_WR_ARB_CNT_EN is defined, o_pkt_cnt0/1 SHALL exist and count as follows:
  - each increments on a last-beat transfer of its requester or on a truncation of its requester;
  - each wraps modulo 2^CntWidth.
- REQ-029: Without FIFO_WR_ARB_CNT_EN, the counters and their ports SHALL be absent, and all other behaviour is identical.

Verification
- REQ-030: Only req0 sends a 3-beat packet A1,A2,A3 -> grant 01 one cycle after valid; wr_en for 3 consecutive cycles with data A1..A3; then IDLE; pkt_cnt0=1.
- REQ-031: Both requesters valid at once after reset, each with a 2-beat packet -> req0 granted first, one bubble cycle, then req1; FIFO order r0b0,r0b1,r1b0,r1b1.
- REQ-032: i_fifo_full high for 4 cycles mid-packet -> ready=0 and wr_en=0 for those 4 cycles; grant held; beats resume in order with none lost or duplicated.
- REQ-033: MaxBeats=4 and req1 streams 6 beats with last only on beat 6 -> o_trunc pulse on beat 4; beats 5-6 written after regrant; pkt_cnt1=2.
- REQ-034: Reset asserted on beat 2 of 4 -> wr_en=0 and grant=00 immediately; after release, a fresh packet from req1 is granted normally.
- REQ-035: req0 drops valid for 3 cycles mid-packet while req1 is valid -> grant stays 01; req1 ready=0 until req0 completes its last beat.
